// File: rtl/nes_pad_responder.sv
// Device side of the NES controller serial link: emulates the pad's 4021 shift register.
// Optional autofire on A/B is enabled with the PAD_AUTOFIRE_EN macro.
module nes_pad_responder #(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int TURBO_DIV      = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  buttons_in,
    input  logic        latch,
    input  logic        ctrl_clk,
    output logic        data,
    output logic        busy,
    output logic        poll_done,
    output logic [15:0] poll_count
);

    // state    | meaning
    // ST_IDLE  | no poll in progress, data released (1)
    // ST_LOAD  | latch high, shift register tracks buttons_in
    // ST_SHIFT | latch low, one bit out per ctrl_clk rise
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2
    } state_t;

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_RELOAD = TW'(TIMEOUT_CYCLES - 1);

    logic [SYNC_STAGES-1:0] latch_sync_q, latch_sync_d;
    logic [SYNC_STAGES-1:0] cclk_sync_q, cclk_sync_d;
    logic                   latch_prev_q, latch_prev_d;
    logic                   cclk_prev_q, cclk_prev_d;

    state_t        state_q, state_d;
    logic [7:0]    shift_q, shift_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          data_q, data_d;
    logic          busy_q, busy_d;
    logic          poll_done_q, poll_done_d;
    logic [15:0]   poll_count_q, poll_count_d;

    logic       latch_s, cclk_s;
    logic       latch_rise, latch_fall, cclk_rise;
    logic [7:0] load_val;

    assign latch_s    = latch_sync_q[SYNC_STAGES-1];
    assign cclk_s     = cclk_sync_q[SYNC_STAGES-1];
    assign latch_rise = latch_s & ~latch_prev_q;
    assign latch_fall = ~latch_s & latch_prev_q;
    assign cclk_rise  = cclk_s & ~cclk_prev_q;

`ifdef PAD_AUTOFIRE_EN
    localparam int TBW = (TURBO_DIV > 1) ? $clog2(TURBO_DIV) : 1;
    logic [TBW-1:0] turbo_cnt_q, turbo_cnt_d;
    logic           turbo_q, turbo_d;

    always_comb begin
        turbo_cnt_d = turbo_cnt_q;
        turbo_d     = turbo_q;
        if (poll_done_q) begin
            if (turbo_cnt_q == TBW'(TURBO_DIV - 1)) begin
                turbo_cnt_d = '0;
                turbo_d     = ~turbo_q;
            end else begin
                turbo_cnt_d = turbo_cnt_q + TBW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            turbo_cnt_q <= '0;
            turbo_q     <= 1'b0;
        end else begin
            turbo_cnt_q <= turbo_cnt_d;
            turbo_q     <= turbo_d;
        end
    end

    assign load_val = {buttons_in[7:2], buttons_in[1:0] & {2{turbo_q}}};
`else
    assign load_val = buttons_in;
`endif

    always_comb begin
        latch_sync_d = {latch_sync_q[SYNC_STAGES-2:0], latch};
        cclk_sync_d  = {cclk_sync_q[SYNC_STAGES-2:0], ctrl_clk};
        latch_prev_d = latch_s;
        cclk_prev_d  = cclk_s;

        state_d      = state_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        tmo_d        = tmo_q;
        poll_done_d  = 1'b0;
        poll_count_d = poll_count_q;

        // A latch rise outranks everything, including a coincident ctrl_clk rise.
        if (latch_rise) begin
            state_d   = ST_LOAD;
            shift_d   = load_val;
            bit_cnt_d = '0;
            tmo_d     = '0;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (latch_s) begin
                        shift_d = load_val;
                    end
                    if (latch_fall) begin
                        state_d = ST_SHIFT;
                        tmo_d   = TMO_RELOAD;
                    end
                end
                ST_SHIFT: begin
                    if (cclk_rise) begin
                        shift_d   = {1'b0, shift_q[7:1]};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        tmo_d     = TMO_RELOAD;
                        if (bit_cnt_q == 4'd7) begin
                            state_d      = ST_IDLE;
                            poll_done_d  = 1'b1;
                            poll_count_d = poll_count_q + 16'd1;
                        end
                    end else if (tmo_q == '0) begin
                        state_d = ST_IDLE;
                    end else begin
                        tmo_d = tmo_q - TW'(1);
                    end
                end
                default: ;
            endcase
        end

        data_d = (state_q == ST_IDLE) ? 1'b1 : ~shift_q[0];
        busy_d = (state_q == ST_LOAD) || (state_q == ST_SHIFT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            latch_sync_q <= '0;
            cclk_sync_q  <= '0;
            latch_prev_q <= 1'b0;
            cclk_prev_q  <= 1'b0;
            state_q      <= ST_IDLE;
            shift_q      <= 8'h00;
            bit_cnt_q    <= '0;
            tmo_q        <= '0;
            data_q       <= 1'b1;
            busy_q       <= 1'b0;
            poll_done_q  <= 1'b0;
            poll_count_q <= '0;
        end else begin
            latch_sync_q <= latch_sync_d;
            cclk_sync_q  <= cclk_sync_d;
            latch_prev_q <= latch_prev_d;
            cclk_prev_q  <= cclk_prev_d;
            state_q      <= state_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            tmo_q        <= tmo_d;
            data_q       <= data_d;
            busy_q       <= busy_d;
            poll_done_q  <= poll_done_d;
            poll_count_q <= poll_count_d;
        end
    end

    assign data       = data_q;
    assign busy       = busy_q;
    assign poll_done  = poll_done_q;
    assign poll_count = poll_count_q;

endmodule
